cam_capture_sync: RTL and testbench
===================================

Name: cam_capture_sync

Overview:
- Capture stage between the OV7670 camera pins and the dual-port frame buffer (DP_RAM) in test_cam.
- Oversamples CAM_PCLK/HREF/VSYNC/data on the system clock and assembles RGB444 pixels from byte pairs.
- Drives DP_RAM write port: addr_in, data_in, regW for a 160x120 frame.
- Runs entirely in the clk domain; CAM_PCLK is treated as data, not as a clock.

Parameters:
IMG_W, 160, pixels per line stored
IMG_H, 120, lines per frame stored
AW, 15, DP_RAM address width (IMG_W*IMG_H = 19200 < 2^15)
DW, 12, pixel width, RGB444

Ports:
clk  in  1  system clock; must be at least 4x CAM_PCLK, with each pclk phase at least 2 clk periods
rst  in  1  asynchronous, active-high reset
CAM_PCLK  in  1  camera pixel clock, sampled
CAM_HREF  in  1  line valid
CAM_VSYNC  in  1  frame sync; high means vertical blank
CAM_px_data  in  8  camera byte
DP_RAM_addr_in  out  AW  write address
DP_RAM_data_in  out  DW  write data {R[3:0],G[3:0],B[3:0]}
DP_RAM_regW  out  1  write strobe, one clk wide
frame_done  out  1  one-clk pulse at the end of a frame
line_err  out  1  sticky flag: odd byte count or over-length line seen; cleared by rst or frame start

Behaviour:
- Reset: all outputs are 0; FSM is WAIT_FRAME; counters are 0.
- Input synchronisation:
  - PCLK, HREF, VSYNC and data each pass through 2 flops, s1 then s2.
  - A third flop s3 holds PCLK only.
  - pclk_rise = s2 & ~s3.
  - HREF, VSYNC and data are used from s2, aligned with pclk_rise.
- FSM states:
  - WAIT_FRAME: wait for synced VSYNC=1. Then clear addr, row, col and line_err, and go to VBLANK.
  - VBLANK: on VSYNC falling (1 to 0), go to LINE_IDLE.
  - LINE_IDLE: on pclk_rise with HREF=1, latch byte[3:0] as R and go to BYTE_LO.
  - BYTE_LO: on pclk_rise with HREF=1, form pixel {R, byte[7:4], byte[3:0]}. Request a write if col<IMG_W and row<IMG_H, then go to BYTE_HI.
  - BYTE_HI: on pclk_rise with HREF=1, latch R and go to BYTE_LO.
  - In any line state, HREF falling ends the line:
    - row++, col=0, row_base += IMG_W.
    - Go to LINE_IDLE.
    - If it falls while in BYTE_LO, the partial byte is discarded and line_err is set.
- Write path:
  - regW, addr_in and data_in are registered outputs.
  - regW rises on the clk edge after the pclk_rise cycle of the second byte.
  - End-to-end latency: regW is high 4 clk edges after the first clk edge that samples CAM_PCLK=1.
  - addr_in = row_base + col; col increments after every requested write.
  - addr_in and data_in hold their value when regW=0.
- Limits:
  - col reaching IMG_W with HREF still high: further pixels are dropped and line_err is set.
  - row at or above IMG_H: all pixels are dropped, with no error.
  - Address never exceeds IMG_W*IMG_H-1 = 19199.
- Frame end:
  - VSYNC rising in any line state: frame_done pulses for 1 clk, provided at least one write occurred in the frame.
  - Then go to VBLANK; counters are cleared on entry.
- Simultaneous events:
  - VSYNC rise has priority over HREF and pclk_rise in the same cycle; the pending byte is discarded.
- Reset mid-frame: immediate return to reset values. The capture waits for the next VSYNC high; the partial frame is never resumed.

Decomposition:
- Shared package cam_pkg holds:
  - IMG_W, IMG_H, AW, DW
  - FSM state enum: WAIT_FRAME, VBLANK, LINE_IDLE, BYTE_HI, BYTE_LO
  - rgb444 field positions
- One sub-module, cam_sync_edge:
  - Parameterised-width 2-flop synchroniser.
  - Extra PCLK stage and rise detector.
  - Instantiated once for the {PCLK, HREF, VSYNC, data} bundle.

Test Plan:
- Reset held for 20 clk, then released with CAM_PCLK toggling and VSYNC=1 -> all outputs stay 0; no regW until VSYNC falls.
- Full frame: 320 bytes/line, 120 lines, 4 blank lines, data alternating 0xFF/0x00 -> exactly 19200 regW pulses, addresses 0..19199 in order, each data_in=12'hF00.
- Single line with bytes 0x0A,0x5C -> one write with data 12'hA5C at addr 0; latency 4 clk from the sampled PCLK rise.
- HREF drops after 3 bytes -> one write only, line_err=1; next line starts at addr 160.
- Line of 330 bytes -> 160 writes, addr ends at 159, line_err=1; 5 pixels dropped.
- VSYNC rises mid-line 50 after writes occurred -> frame_done pulses once; next frame's first write is at addr 0 with line_err cleared.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants, FSM states and RGB444 packing for the camera capture path.
// Frame geometry matches the 160x120 DP_RAM frame buffer.
package cam_pkg;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int AW    = 15;
  localparam int DW    = 12;

  // RGB444 field positions inside a DW-bit pixel
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    WAIT_FRAME,
    VBLANK,
    LINE_IDLE,
    BYTE_HI,
    BYTE_LO
  } state_t;

  function automatic logic [DW-1:0] pack_rgb(
    input logic [3:0] r,
    input logic [3:0] g,
    input logic [3:0] b
  );
    logic [DW-1:0] p;
    p = '0;
    p[R_LSB +: 4] = r;
    p[G_LSB +: 4] = g;
    p[B_LSB +: 4] = b;
    return p;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for the camera pin bundle plus PCLK rise detect.
// Ports: d = {PCLK, rest}, q = synced rest, rise = one-clk PCLK rise.
module cam_sync_edge #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-2:0] q,
  output logic         rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2[W-1];
    end
  end

  // rest of the bundle leaves from s2 so it lines up with rise
  assign q    = s2[W-2:0];
  assign rise = s2[W-1] & ~s3;

endmodule

// File: rtl/cam_capture_sync.sv
// OV7670 capture: oversampled pins -> RGB444 pixels -> DP_RAM write port.
// Ports: clk/rst, CAM_* camera pins, DP_RAM_* write port, frame_done, line_err.
module cam_capture_sync
  import cam_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_PCLK,
  input  logic          CAM_HREF,
  input  logic          CAM_VSYNC,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          line_err
);

  localparam int            SW        = 11;
  localparam logic [7:0]    COL_LIM   = 8'(IMG_W);
  localparam logic [7:0]    ROW_LIM   = 8'(IMG_H);
  localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);

  logic [SW-2:0] syn;
  logic          pclk_rise;
  logic          href;
  logic          vsync;
  logic [7:0]    px;

  cam_sync_edge #(
    .W(SW)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_px_data}),
    .q    (syn),
    .rise (pclk_rise)
  );

  assign href  = syn[9];
  assign vsync = syn[8];
  assign px    = syn[7:0];

  logic href_d;
  logic vsync_d;
  logic href_fall;
  logic vsync_rise;
  logic vsync_fall;

  assign href_fall  = href_d & ~href;
  assign vsync_rise = ~vsync_d & vsync;
  assign vsync_fall = vsync_d & ~vsync;

  state_t        state;
  logic [3:0]    red;
  logic [7:0]    col;
  logic [7:0]    row;
  logic [AW-1:0] row_base;
  logic          wrote;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= WAIT_FRAME;
      href_d         <= 1'b0;
      vsync_d        <= 1'b0;
      red            <= '0;
      col            <= '0;
      row            <= '0;
      row_base       <= '0;
      wrote          <= 1'b0;
      wr_req         <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      frame_done     <= 1'b0;
      line_err       <= 1'b0;
    end else begin
      href_d      <= href;
      vsync_d     <= vsync;
      wr_req      <= 1'b0;
      frame_done  <= 1'b0;
      // output stage: addr/data only move with a strobe
      DP_RAM_regW <= wr_req;
      if (wr_req) begin
        DP_RAM_addr_in <= wr_addr;
        DP_RAM_data_in <= wr_data;
      end
      unique case (state)
        WAIT_FRAME: begin
          if (vsync) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            line_err <= 1'b0;
            wrote    <= 1'b0;
            state    <= VBLANK;
          end
        end
        VBLANK: begin
          if (vsync_fall) state <= LINE_IDLE;
        end
        LINE_IDLE, BYTE_HI, BYTE_LO: begin
          if (vsync_rise) begin
            // pending half-pixel is simply abandoned
            frame_done <= wrote;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            line_err   <= 1'b0;
            wrote      <= 1'b0;
            state      <= VBLANK;
          end else if (href_fall) begin
            if (state == BYTE_LO) line_err <= 1'b1;
            // row saturates so row_base never passes the frame end
            if (row < ROW_LIM) begin
              row      <= row + 8'd1;
              row_base <= row_base + LINE_STEP;
            end
            col   <= '0;
            state <= LINE_IDLE;
          end else if (pclk_rise && href) begin
            if (state == BYTE_LO) begin
              if (row < ROW_LIM) begin
                if (col < COL_LIM) begin
                  wr_req  <= 1'b1;
                  wr_addr <= row_base + AW'(col);
                  wr_data <= pack_rgb(red, px[7:4], px[3:0]);
                  col     <= col + 8'd1;
                  wrote   <= 1'b1;
                end else begin
                  line_err <= 1'b1;
                end
              end
              state <= BYTE_HI;
            end else begin
              red   <= px[3:0];
              state <= BYTE_LO;
            end
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_sync.sv
// Randomised bench for cam_capture_sync against a frame-level write model.
// Drives OV7670-style PCLK/HREF/VSYNC and scoreboards every DP_RAM write.
module tb_cam_capture_sync;
  import cam_pkg::*;

  logic          clk;
  logic          rst;
  logic          CAM_PCLK;
  logic          CAM_HREF;
  logic          CAM_VSYNC;
  logic [7:0]    CAM_px_data;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          DP_RAM_regW;
  logic          frame_done;
  logic          line_err;

  cam_capture_sync dut (
    .clk            (clk),
    .rst            (rst),
    .CAM_PCLK       (CAM_PCLK),
    .CAM_HREF       (CAM_HREF),
    .CAM_VSYNC      (CAM_VSYNC),
    .CAM_px_data    (CAM_px_data),
    .DP_RAM_addr_in (DP_RAM_addr_in),
    .DP_RAM_data_in (DP_RAM_data_in),
    .DP_RAM_regW    (DP_RAM_regW),
    .frame_done     (frame_done),
    .line_err       (line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  nchk;
  int  nerr;
  int  fd_cnt;
  int  m_row;
  bit  m_err;
  bit  m_wrote;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every strobe must match the next modelled write
  always @(posedge clk) begin
    #1;
    if (rst) begin
      last_a = '0;
      last_d = '0;
    end else begin
      if (frame_done) fd_cnt++;
      if (DP_RAM_regW) begin
        if (exp_q.size() == 0) begin
          chk("spurious_regW", DP_RAM_regW, 0);
        end else begin
          e = exp_q.pop_front();
          chk("addr", DP_RAM_addr_in, e.a);
          chk("data", DP_RAM_data_in, e.d);
          last_a = e.a;
          last_d = e.d;
        end
      end else begin
        chk("addr_hold", DP_RAM_addr_in, last_a);
        chk("data_hold", DP_RAM_data_in, last_d);
      end
    end
  end

  task automatic tick(input logic h, input logic [7:0] d);
    CAM_PCLK    = 1'b0;
    CAM_HREF    = h;
    CAM_px_data = d;
    repeat ($urandom_range(2, 3)) @(negedge clk);
    CAM_PCLK = 1'b1;
    repeat ($urandom_range(2, 3)) @(negedge clk);
  endtask

  task automatic push_bytes(input int n, input bit alt);
    logic [7:0] b;
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (alt) b = (i % 2 == 0) ? 8'hFF : 8'h00;
      else     b = 8'($urandom);
      if (i % 2 == 0) begin
        r = b;
      end else if (m_row < IMG_H && i / 2 < IMG_W) begin
        exp_q.push_back('{a: AW'(m_row * IMG_W + i / 2),
                          d: {r[3:0], b}});
        m_wrote = 1'b1;
      end
      tick(1'b1, b);
    end
  endtask

  task automatic end_line(input int n);
    if (n % 2 == 1) m_err = 1'b1;
    if (n / 2 > IMG_W && m_row < IMG_H) m_err = 1'b1;
    m_row++;
    repeat (4) tick(1'b0, 8'h00);
    chk("line_err", line_err, m_err);
  endtask

  task automatic send_line(input int n, input bit alt);
    push_bytes(n, alt);
    end_line(n);
  endtask

  task automatic frame_begin();
    CAM_VSYNC = 1'b1;
    repeat (4) tick(1'b0, 8'h00);
    CAM_VSYNC = 1'b0;
    repeat (3) tick(1'b0, 8'h00);
    m_row   = 0;
    m_err   = 1'b0;
    m_wrote = 1'b0;
  endtask

  task automatic frame_end();
    int fd0;
    fd0 = fd_cnt;
    CAM_VSYNC = 1'b1;
    repeat (3) tick(1'b0, 8'h00);
    chk("frame_done", fd_cnt - fd0, m_wrote ? 1 : 0);
    chk("q_drained", exp_q.size(), 0);
    m_err = 1'b0;
    chk("line_err_clr", line_err, m_err);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_regW"}, DP_RAM_regW, 0);
    chk({tag, "_addr"}, DP_RAM_addr_in, 0);
    chk({tag, "_data"}, DP_RAM_data_in, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_err"}, line_err, 0);
  endtask

  initial begin
    int fd0;
    nchk = 0;
    nerr = 0;
    fd_cnt = 0;
    m_row = 0;
    m_err = 1'b0;
    m_wrote = 1'b0;
    rst = 1'b1;
    CAM_PCLK = 1'b0;
    CAM_HREF = 1'b0;
    CAM_VSYNC = 1'b1;
    CAM_px_data = 8'h00;

    // reset held 20 clk with PCLK running
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 2 == 1) CAM_PCLK = ~CAM_PCLK;
      CAM_px_data = 8'($urandom);
      if (i == 10) chk_idle("rst");
    end
    rst = 1'b0;
    // vertical blank with line activity: nothing written
    repeat (6) tick(1'b1, 8'($urandom));
    repeat (2) tick(1'b0, 8'h00);
    chk_idle("vblank");

    // frame 1: latency pixel, then an over-length line
    frame_begin();
    tick(1'b1, 8'h0A);
    exp_q.push_back('{a: AW'(0), d: 12'hA5C});
    m_wrote = 1'b1;
    CAM_PCLK = 1'b0;
    CAM_px_data = 8'h5C;
    repeat (2) @(negedge clk);
    CAM_PCLK = 1'b1;
    // strobe lands on the 4th edge counting the sampling edge
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat_early", DP_RAM_regW, 0);
    @(posedge clk);
    #1 chk("lat_regW", DP_RAM_regW, 1);
    @(negedge clk);
    end_line(2);
    send_line(330, 1'b0);
    frame_end();

    // frame 2: odd-length line then a normal one
    frame_begin();
    send_line(3, 1'b0);
    send_line(4, 1'b0);
    frame_end();

    // frame 3: full-width lines at both ends of the frame
    frame_begin();
    for (int l = 0; l < 122; l++) begin
      if (l < 4 || l == 119) send_line(2 * IMG_W, 1'b0);
      else if (l == 120)     send_line(330, 1'b0);
      else                   send_line(2 * $urandom_range(1, 3), 1'b0);
    end
    frame_end();

    // frame 4: VSYNC rises mid-line after 50 writes
    frame_begin();
    send_line(2 * IMG_W, 1'b1);
    push_bytes(100, 1'b1);
    fd0 = fd_cnt;
    CAM_VSYNC = 1'b1;
    repeat (3) tick(1'b1, 8'hFF);
    repeat (2) tick(1'b0, 8'h00);
    chk("fd_midline", fd_cnt - fd0, 1);
    chk("q_midline", exp_q.size(), 0);
    m_err = 1'b0;
    chk("err_midline", line_err, m_err);

    // frame 5: restarts at address 0, then reset mid-frame
    frame_begin();
    send_line(4, 1'b0);
    send_line(3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midrst");
    rst = 1'b0;
    // no VSYNC high seen yet: this line must be ignored
    m_row = IMG_H;
    m_err = 1'b0;
    m_wrote = 1'b0;
    send_line(4, 1'b0);

    // frame 6: capture resumes on a fresh frame
    frame_begin();
    send_line(6, 1'b0);
    frame_end();

    // frame 7: no pixels, no frame_done
    frame_begin();
    repeat (4) tick(1'b0, 8'h00);
    frame_end();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
